tl_sram_bridge: RTL and testbench

//  TileLink-UL/UH slave terminating one slave port of the 1-to-N crossbar into a synchronous single-port SRAM.

---
 rtl/tl_sram_bridge.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_tl_sram_bridge.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_sram_bridge.sv
// tl_sram_bridge: TileLink-UL/UH slave port terminating into a single-port synchronous SRAM.
// Define TL_SRAM_BRIDGE_RANGE_CHECK_EN to deny requests addressed beyond the SRAM footprint.
module tl_sram_bridge #(
    parameter int unsigned TL_DW  = 32,
    parameter int unsigned TL_AW  = 32,
    parameter int unsigned TL_RS  = 4,
    parameter int unsigned TL_SZ  = 4,
    parameter int unsigned MEM_AW = 12
) (
    input  logic                 tilelink_clock_i,
    input  logic                 tilelink_reset_ni,
    input  logic [2:0]           slave_a_opcode,
    input  logic [2:0]           slave_a_param,
    input  logic [TL_SZ-1:0]     slave_a_size,
    input  logic [TL_RS-1:0]     slave_a_source,
    input  logic [TL_AW-1:0]     slave_a_address,
    input  logic [TL_DW/8-1:0]   slave_a_mask,
    input  logic [TL_DW-1:0]     slave_a_data,
    input  logic                 slave_a_corrupt,
    input  logic                 slave_a_valid,
    output logic                 slave_a_ready,
    output logic [2:0]           slave_d_opcode,
    output logic [1:0]           slave_d_param,
    output logic [TL_SZ-1:0]     slave_d_size,
    output logic [TL_RS-1:0]     slave_d_source,
    output logic                 slave_d_denied,
    output logic [TL_DW-1:0]     slave_d_data,
    output logic                 slave_d_corrupt,
    output logic                 slave_d_valid,
    input  logic                 slave_d_ready,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [MEM_AW-1:0]    mem_addr_o,
    output logic [TL_DW/8-1:0]   mem_wmask_o,
    output logic [TL_DW-1:0]     mem_wdata_o,
    input  logic [TL_DW-1:0]     mem_rdata_i
);

    localparam int unsigned Lb = $clog2(TL_DW / 8);
    localparam int unsigned Mw = TL_DW / 8;

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDeny, StAck} state_e;

    typedef struct packed {
        logic             op;
        logic [TL_SZ-1:0] size;
        logic [TL_RS-1:0] source;
        logic             denied;
        logic [TL_DW-1:0] data;
    } rsp_t;

    state_e            state_q, state_d;
    logic              alive_q;
    logic [TL_SZ-1:0]  size_q, size_d;
    logic [TL_RS-1:0]  source_q, source_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [Mw-1:0]     wr_mask_q, wr_mask_d;
    logic [TL_DW-1:0]  wr_data_q, wr_data_d;
    logic              wr_pend_q, wr_pend_d;
    logic [11:0]       rem_q, rem_d;
    logic [11:0]       cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              rsp_op_q, rsp_op_d;
    logic              denied_q, denied_d;
    logic              infl_q;
    rsp_t              buf0_q, buf0_d, buf1_q, buf1_d, rsp_new;
    logic [1:0]        occ_q, occ_d;

    logic              a_fire, d_fire, rd_issue, ack_push, rsp_push, a_oor;
    logic [11:0]       a_beats_m1;
    logic [MEM_AW-1:0] a_word;
    logic [Mw-1:0]     a_mask_eff;
    logic              unused_inputs;

    assign unused_inputs = ^{slave_a_param, slave_a_address};

`ifdef TL_SRAM_BRIDGE_RANGE_CHECK_EN
    assign a_oor = |(slave_a_address >> (MEM_AW + Lb));
`else
    assign a_oor = 1'b0;
`endif

    assign a_word     = slave_a_address[MEM_AW+Lb-1:Lb];
    assign a_mask_eff = slave_a_corrupt ? '0 : slave_a_mask;

    always_comb begin
        a_beats_m1 = '0;
        if (slave_a_size > TL_SZ'(Lb)) begin
            a_beats_m1 = 12'((32'd1 << (slave_a_size - TL_SZ'(Lb))) - 32'd1);
        end
    end

    always_comb begin
        slave_a_ready = 1'b0;
        case (state_q)
            StIdle:          slave_a_ready = alive_q;
            StWrite, StDeny: slave_a_ready = (rem_q != 12'd0);
            default:         slave_a_ready = 1'b0;
        endcase
    end

    assign slave_d_valid = (occ_q != 2'd0);
    assign a_fire        = slave_a_valid & slave_a_ready;
    assign d_fire        = slave_d_valid & slave_d_ready;
    // A D handshake in the same cycle frees a slot, which keeps bursts at one beat per cycle.
    assign rd_issue = (state_q == StRead) && !done_q &&
                      (({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, d_fire}));
    assign ack_push = (state_q == StAck) && !done_q && ((occ_q != 2'd2) || d_fire);
    assign rsp_push = infl_q | ack_push;

    always_comb begin
        rsp_new        = '0;
        rsp_new.size   = size_q;
        rsp_new.source = source_q;
        if (infl_q) begin
            rsp_new.op   = 1'b1;
            rsp_new.data = mem_rdata_i;
        end else begin
            rsp_new.op     = rsp_op_q;
            rsp_new.denied = denied_q;
        end
    end

    // Two-entry shift buffer; buf0 is always the head presented on D.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({rsp_push, d_fire})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = rsp_new;
                else               buf1_d = rsp_new;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = rsp_new;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rsp_new;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        source_d  = source_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_mask_d = wr_mask_q;
        wr_data_d = wr_data_q;
        wr_pend_d = 1'b0;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        rsp_op_d  = rsp_op_q;
        denied_d  = denied_q;
        case (state_q)
            StIdle: begin
                if (a_fire) begin
                    size_d   = slave_a_size;
                    source_d = slave_a_source;
                    done_d   = 1'b0;
                    denied_d = 1'b1;
                    rem_d    = 12'd0;
                    cnt_d    = 12'd0;
                    rsp_op_d = 1'b0;
                    state_d  = StDeny;
                    case (slave_a_opcode)
                        3'd0, 3'd1: begin
                            rem_d = a_beats_m1;
                            if (!a_oor) begin
                                state_d   = StWrite;
                                denied_d  = slave_a_corrupt;
                                wr_pend_d = 1'b1;
                                wr_addr_d = a_word;
                                wr_mask_d = a_mask_eff;
                                wr_data_d = slave_a_data;
                                addr_d    = a_word + MEM_AW'(1);
                            end
                        end
                        3'd4: begin
                            rsp_op_d = 1'b1;
                            cnt_d    = a_beats_m1;
                            if (!a_oor) begin
                                state_d  = StRead;
                                denied_d = 1'b0;
                                addr_d   = a_word;
                            end
                        end
                        3'd2, 3'd3: begin
                            rem_d    = a_beats_m1;
                            rsp_op_d = 1'b1;
                            cnt_d    = a_beats_m1;
                        end
                        default: ;
                    endcase
                end
            end
            StWrite: begin
                if (a_fire) begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = addr_q;
                    wr_mask_d = a_mask_eff;
                    wr_data_d = slave_a_data;
                    addr_d    = addr_q + MEM_AW'(1);
                    rem_d     = rem_q - 12'd1;
                    if (slave_a_corrupt) denied_d = 1'b1;
                end
                if (wr_pend_q && (rem_q == 12'd0)) begin
                    state_d  = StAck;
                    cnt_d    = 12'd0;
                    rsp_op_d = 1'b0;
                    done_d   = 1'b0;
                end
            end
            StDeny: begin
                if (a_fire) rem_d = rem_q - 12'd1;
                if (rem_q == 12'd0) state_d = StAck;
            end
            StRead: begin
                if (rd_issue) begin
                    addr_d = addr_q + MEM_AW'(1);
                    if (cnt_q == 12'd0) done_d = 1'b1;
                    else                cnt_d  = cnt_q - 12'd1;
                end
                if (done_q && !infl_q && (occ_q == 2'd1) && d_fire) state_d = StIdle;
            end
            StAck: begin
                if (ack_push) begin
                    if (cnt_q == 12'd0) done_d = 1'b1;
                    else                cnt_d  = cnt_q - 12'd1;
                end
                if (done_q && (occ_q == 2'd1) && d_fire) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
        if (!tilelink_reset_ni) begin
            state_q   <= StIdle;
            alive_q   <= 1'b0;
            size_q    <= '0;
            source_q  <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_mask_q <= '0;
            wr_data_q <= '0;
            wr_pend_q <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            rsp_op_q  <= 1'b0;
            denied_q  <= 1'b0;
            infl_q    <= 1'b0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            alive_q   <= 1'b1;
            size_q    <= size_d;
            source_q  <= source_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_mask_q <= wr_mask_d;
            wr_data_q <= wr_data_d;
            wr_pend_q <= wr_pend_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            rsp_op_q  <= rsp_op_d;
            denied_q  <= denied_d;
            infl_q    <= rd_issue;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            occ_q     <= occ_d;
        end
    end

    assign slave_d_opcode  = {2'b00, buf0_q.op};
    assign slave_d_param   = 2'b00;
    assign slave_d_size    = buf0_q.size;
    assign slave_d_source  = buf0_q.source;
    assign slave_d_denied  = buf0_q.denied;
    assign slave_d_data    = buf0_q.data;
    assign slave_d_corrupt = 1'b0;

    assign mem_en_o    = wr_pend_q | rd_issue;
    assign mem_we_o    = wr_pend_q;
    assign mem_addr_o  = wr_pend_q ? wr_addr_q : addr_q;
    assign mem_wmask_o = wr_pend_q ? wr_mask_q : '0;
    assign mem_wdata_o = wr_pend_q ? wr_data_q : '0;

endmodule

// File: tb/tb_tl_sram_bridge.sv
// tb_tl_sram_bridge: directed stimulus with a response scoreboard for tl_sram_bridge.
// A behavioural SRAM model sits on the memory port.
module tb_tl_sram_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [3:0]  a_size = '0;
    logic [3:0]  a_source = '0;
    logic [31:0] a_address = '0;
    logic [3:0]  a_mask = '0;
    logic [31:0] a_data = '0;
    logic        a_corrupt = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready = 1'b1;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] sram [0:4095];
    logic [46:0] exp_q [$];
    int          hs_cyc [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_mem = 0;
    int          cyc = 0;
    int          ready_mode = 0;

    tl_sram_bridge dut (
        .tilelink_clock_i (clk),
        .tilelink_reset_ni(rst_n),
        .slave_a_opcode   (a_opcode),
        .slave_a_param    (a_param),
        .slave_a_size     (a_size),
        .slave_a_source   (a_source),
        .slave_a_address  (a_address),
        .slave_a_mask     (a_mask),
        .slave_a_data     (a_data),
        .slave_a_corrupt  (a_corrupt),
        .slave_a_valid    (a_valid),
        .slave_a_ready    (a_ready),
        .slave_d_opcode   (d_opcode),
        .slave_d_param    (d_param),
        .slave_d_size     (d_size),
        .slave_d_source   (d_source),
        .slave_d_denied   (d_denied),
        .slave_d_data     (d_data),
        .slave_d_corrupt  (d_corrupt),
        .slave_d_valid    (d_valid),
        .slave_d_ready    (d_ready),
        .mem_en_o         (mem_en),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_wmask_o      (mem_wmask),
        .mem_wdata_o      (mem_wdata),
        .mem_rdata_i      (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [46:0] mk(input logic [2:0] op, input logic [3:0] sz,
                                       input logic [3:0] src, input logic den,
                                       input logic [31:0] data);
        return {op, 2'b00, sz, src, den, data, 1'b0};
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            1:       d_ready = ~d_ready;
            2:       d_ready = 1'b0;
            default: d_ready = 1'b1;
        endcase
    end

    // Monitor: scoreboard pop on every D handshake, plus payload stability while stalled.
    initial begin
        logic [46:0] prev;
        logic [46:0] act;
        logic [46:0] e;
        bit          hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            act = {d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt};
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (mem_en) n_mem++;
                if (hold) chk("d_stable", {17'd0, d_valid, act}, {17'd0, 1'b1, prev});
                if (d_valid && d_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("d_unexpected", {17'd0, act}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("d_beat", {17'd0, act}, {17'd0, e});
                        hs_cyc.push_back(cyc);
                    end
                end
                hold = d_valid && !d_ready;
                prev = act;
            end
        end
    end

    task automatic a_send(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                          input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input logic corrupt);
        bit ok;
        ok = 1'b0;
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corrupt;
        a_valid   = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = a_ready;
            @(posedge clk);
            #1;
        end
        a_valid   = 1'b0;
        a_corrupt = 1'b0;
        if (!ok) chk("a_handshake", {63'd0, ok}, 64'd1);
    endtask

    task automatic put_burst(input logic [3:0] src, input logic [31:0] addr,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3, input int bad);
        logic [31:0] w [4];
        w[0] = d0; w[1] = d1; w[2] = d2; w[3] = d3;
        for (int i = 0; i < 4; i++) a_send(3'd0, 4'd4, src, addr, 4'hF, w[i], (i == bad));
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !d_valid) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("drain", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        int m0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d_valid", {63'd0, d_valid}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_a_ready", {63'd0, a_ready}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_a_ready", {63'd0, a_ready}, 64'd1);

        // 1: full put then get, with get latency
        exp_q.push_back(mk(3'd0, 4'd2, 4'd1, 1'b0, 32'h0));
        a_send(3'd0, 4'd2, 4'd1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        wait_drain();
        exp_q.push_back(mk(3'd1, 4'd2, 4'd2, 1'b0, 32'hDEADBEEF));
        a_send(3'd4, 4'd2, 4'd2, 32'h10, 4'hF, 32'h0, 1'b0);
        chk("get_lat_e0", {63'd0, d_valid}, 64'd0);
        @(posedge clk); #1;
        chk("get_lat_e1", {63'd0, d_valid}, 64'd0);
        @(posedge clk); #1;
        chk("get_lat_e2", {63'd0, d_valid}, 64'd1);
        wait_drain();

        // 2: partial put merges into existing word
        exp_q.push_back(mk(3'd0, 4'd2, 4'd3, 1'b0, 32'h0));
        a_send(3'd0, 4'd2, 4'd3, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b0);
        exp_q.push_back(mk(3'd0, 4'd2, 4'd3, 1'b0, 32'h0));
        a_send(3'd1, 4'd2, 4'd3, 32'h20, 4'h3, 32'h0000AAAA, 1'b0);
        exp_q.push_back(mk(3'd1, 4'd2, 4'd4, 1'b0, 32'hFFFFAAAA));
        a_send(3'd4, 4'd2, 4'd4, 32'h20, 4'hF, 32'h0, 1'b0);
        wait_drain();

        // 3: burst put, burst get at full rate, then burst get with stalls
        exp_q.push_back(mk(3'd0, 4'd4, 4'd3, 1'b0, 32'h0));
        put_burst(4'd3, 32'h40, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, -1);
        wait_drain();
        hs_cyc.delete();
        exp_q.push_back(mk(3'd1, 4'd4, 4'd5, 1'b0, 32'h11111111));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd5, 1'b0, 32'h22222222));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd5, 1'b0, 32'h33333333));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd5, 1'b0, 32'h44444444));
        a_send(3'd4, 4'd4, 4'd5, 32'h40, 4'hF, 32'h0, 1'b0);
        wait_drain();
        chk("burst_beats", 64'(hs_cyc.size()), 64'd4);
        if (hs_cyc.size() == 4) chk("burst_span", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
        ready_mode = 1;
        exp_q.push_back(mk(3'd1, 4'd4, 4'd6, 1'b0, 32'h11111111));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd6, 1'b0, 32'h22222222));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd6, 1'b0, 32'h33333333));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd6, 1'b0, 32'h44444444));
        a_send(3'd4, 4'd4, 4'd6, 32'h40, 4'hF, 32'h0, 1'b0);
        wait_drain();
        ready_mode = 0;

        // 4: corrupt beat leaves its word unchanged and denies the ack
        exp_q.push_back(mk(3'd0, 4'd2, 4'd2, 1'b0, 32'h0));
        a_send(3'd0, 4'd2, 4'd2, 32'h88, 4'hF, 32'h5A5A5A5A, 1'b0);
        exp_q.push_back(mk(3'd0, 4'd4, 4'd2, 1'b1, 32'h0));
        put_burst(4'd2, 32'h80, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hBAD0BAD0, 32'hA3A3A3A3, 2);
        wait_drain();
        exp_q.push_back(mk(3'd1, 4'd4, 4'd1, 1'b0, 32'hA0A0A0A0));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd1, 1'b0, 32'hA1A1A1A1));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd1, 1'b0, 32'h5A5A5A5A));
        exp_q.push_back(mk(3'd1, 4'd4, 4'd1, 1'b0, 32'hA3A3A3A3));
        a_send(3'd4, 4'd4, 4'd1, 32'h80, 4'hF, 32'h0, 1'b0);
        wait_drain();

        // 5: arithmetic is denied without touching memory
        m0 = n_mem;
        exp_q.push_back(mk(3'd1, 4'd2, 4'd7, 1'b1, 32'h0));
        a_send(3'd2, 4'd2, 4'd7, 32'h10, 4'hF, 32'h1, 1'b0);
        wait_drain();
        chk("arith_no_mem", 64'(n_mem - m0), 64'd0);
        exp_q.push_back(mk(3'd1, 4'd2, 4'd7, 1'b0, 32'hDEADBEEF));
        a_send(3'd4, 4'd2, 4'd7, 32'h10, 4'hF, 32'h0, 1'b0);
        wait_drain();

        // 6: reset in the middle of a stalled read burst
        ready_mode = 2;
        @(posedge clk); #1;
        a_send(3'd4, 4'd4, 4'd8, 32'h40, 4'hF, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d_valid", {63'd0, d_valid}, 64'd0);
        chk("mid_rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("mid_rst_a_ready", {63'd0, a_ready}, 64'd0);
        exp_q.delete();
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(3'd1, 4'd2, 4'd8, 1'b0, 32'h22222222));
        a_send(3'd4, 4'd2, 4'd8, 32'h44, 4'hF, 32'h0, 1'b0);
        wait_drain();

        // Upper address bits: denied with range checking, aliased without it
        m0 = n_mem;
`ifdef TL_SRAM_BRIDGE_RANGE_CHECK_EN
        exp_q.push_back(mk(3'd1, 4'd2, 4'd9, 1'b1, 32'h0));
        a_send(3'd4, 4'd2, 4'd9, 32'h80000000, 4'hF, 32'h0, 1'b0);
        wait_drain();
        chk("range_no_mem", 64'(n_mem - m0), 64'd0);
`else
        exp_q.push_back(mk(3'd1, 4'd2, 4'd9, 1'b0, 32'hDEADBEEF));
        a_send(3'd4, 4'd2, 4'd9, 32'h80000010, 4'hF, 32'h0, 1'b0);
        wait_drain();
        chk("alias_one_read", 64'(n_mem - m0), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
